tl_ul_reg_responder: RTL and testbench

- TileLink-UL manager (responder) endpoint: accepts A-channel requests from a bus bypass/crossbar outbound port and returns D-channel responses.
- Backs a small 32-bit register file.
- Denies out-of-range, misaligned and unsupported requests the way an error device would, so a bypassed path and the real target behave consistently.
- Single outstanding transaction, with a configurable response delay.

---
 rtl/tl_ul_reg_responder.sv | 148 ++++++++++++++
 tb/tb_tl_ul_reg_responder.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_reg_responder.sv
// TileLink-UL responder backed by a small 32-bit register file.
// One transaction in flight at a time. An optional delay is inserted between
// request acceptance and the D-channel response. Requests that are misaligned,
// out of range or use an unsupported opcode get a denied response, matching
// what an error device would return.
//
// state | meaning
// IDLE  | a_ready=1, waiting for a request
// WAIT  | request captured, counting down RESP_DELAY idle cycles
// RESP  | d_valid=1, holding the response until d_ready
module tl_ul_reg_responder #(
  parameter int NUM_REGS   = 16,
  parameter int RESP_DELAY = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_in_a_valid,
  output logic        auto_in_a_ready,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [8:0]  auto_in_a_bits_address,
  input  logic        auto_in_a_bits_source,
  input  logic [31:0] auto_in_a_bits_data,
  output logic        auto_in_d_valid,
  input  logic        auto_in_d_ready,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_param,
  output logic [1:0]  auto_in_d_bits_size,
  output logic        auto_in_d_bits_source,
  output logic        auto_in_d_bits_sink,
  output logic        auto_in_d_bits_denied,
  output logic [31:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  delay_cnt;
  logic [31:0] regs [NUM_REGS];

  logic [6:0]       idx;
  logic [IDX_W-1:0] reg_idx;
  logic             misaligned;
  logic             out_of_range;
  logic             is_put;
  logic             is_get;
  logic             is_arith;
  logic             denied_c;
  logic             accept;
  logic             wr_en;
  logic [2:0]       d_opcode_c;
  logic             corrupt_c;
  logic [31:0]      rd_data_c;

  assign idx          = auto_in_a_bits_address[8:2];
  assign reg_idx      = idx[IDX_W-1:0];
  assign misaligned   = |auto_in_a_bits_address[1:0];
  assign out_of_range = int'(idx) >= NUM_REGS;

  assign is_put   = (auto_in_a_bits_opcode == 3'd0) || (auto_in_a_bits_opcode == 3'd1);
  assign is_get   = (auto_in_a_bits_opcode == 3'd4);
  assign is_arith = (auto_in_a_bits_opcode == 3'd2) || (auto_in_a_bits_opcode == 3'd3);
  assign denied_c = misaligned | out_of_range | ~(is_put | is_get);

  assign accept = (state == IDLE) && auto_in_a_valid;
  // No byte mask exists, so PutPartialData is a full-word write like PutFullData.
  assign wr_en  = accept & is_put & ~denied_c;

  // Arithmetic/Logical expect data back, so they answer with AccessAckData (corrupt).
  assign d_opcode_c = (is_get | is_arith) ? 3'd1 : 3'd0;
  assign corrupt_c  = (is_get & denied_c) | is_arith;
  assign rd_data_c  = (is_get & ~denied_c) ? regs[reg_idx] : 32'd0;

  assign auto_in_d_bits_param = 2'd0;
  assign auto_in_d_bits_size  = 2'd2;
  assign auto_in_d_bits_sink  = 1'b0;

  // Register file: cleared on reset, written at the acceptance edge of a legal Put.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
    end else if (wr_en) begin
      regs[reg_idx] <= auto_in_a_bits_data;
    end
  end

  // Request/response sequencer with registered handshake and D-channel outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      auto_in_a_ready        <= 1'b1;
      auto_in_d_valid        <= 1'b0;
      auto_in_d_bits_opcode  <= 3'd0;
      auto_in_d_bits_source  <= 1'b0;
      auto_in_d_bits_denied  <= 1'b0;
      auto_in_d_bits_data    <= 32'd0;
      auto_in_d_bits_corrupt <= 1'b0;
      delay_cnt              <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (auto_in_a_valid) begin
            auto_in_a_ready        <= 1'b0;
            auto_in_d_bits_opcode  <= d_opcode_c;
            auto_in_d_bits_source  <= auto_in_a_bits_source;
            auto_in_d_bits_denied  <= denied_c;
            auto_in_d_bits_data    <= rd_data_c;
            auto_in_d_bits_corrupt <= corrupt_c;
            if (RESP_DELAY > 0) begin
              state     <= WAIT;
              delay_cnt <= 4'(RESP_DELAY - 1);
            end else begin
              state           <= RESP;
              auto_in_d_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (delay_cnt == 4'd0) begin
            state           <= RESP;
            auto_in_d_valid <= 1'b1;
          end else begin
            delay_cnt <= delay_cnt - 4'd1;
          end
        end
        RESP: begin
          if (auto_in_d_ready) begin
            state           <= IDLE;
            auto_in_d_valid <= 1'b0;
            auto_in_a_ready <= 1'b1;
          end
        end
        default: begin
          state           <= IDLE;
          auto_in_d_valid <= 1'b0;
          auto_in_a_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tl_ul_reg_responder.sv
// Bench for tl_ul_reg_responder: unit 0 with no response delay, unit 1 with
// a delay of 3, sharing clock and reset. Expected responses come from a
// word-array model of the register file and the opcode rules.
module tb_tl_ul_reg_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid [2];
  logic        a_ready [2];
  logic [2:0]  a_op    [2];
  logic [8:0]  a_addr  [2];
  logic        a_src   [2];
  logic [31:0] a_data  [2];
  logic        d_valid [2];
  logic        d_ready [2];
  logic [2:0]  d_op    [2];
  logic [1:0]  d_param [2];
  logic [1:0]  d_size  [2];
  logic        d_src   [2];
  logic        d_sink  [2];
  logic        d_den   [2];
  logic [31:0] d_data  [2];
  logic        d_cor   [2];

  logic [31:0] mem [2][16];
  int total = 0;
  int bad = 0;

  tl_ul_reg_responder #(.NUM_REGS(16), .RESP_DELAY(0)) u0 (
    .clock(clk), .reset(rst),
    .auto_in_a_valid(a_valid[0]), .auto_in_a_ready(a_ready[0]),
    .auto_in_a_bits_opcode(a_op[0]), .auto_in_a_bits_address(a_addr[0]),
    .auto_in_a_bits_source(a_src[0]), .auto_in_a_bits_data(a_data[0]),
    .auto_in_d_valid(d_valid[0]), .auto_in_d_ready(d_ready[0]),
    .auto_in_d_bits_opcode(d_op[0]), .auto_in_d_bits_param(d_param[0]),
    .auto_in_d_bits_size(d_size[0]), .auto_in_d_bits_source(d_src[0]),
    .auto_in_d_bits_sink(d_sink[0]), .auto_in_d_bits_denied(d_den[0]),
    .auto_in_d_bits_data(d_data[0]), .auto_in_d_bits_corrupt(d_cor[0])
  );

  tl_ul_reg_responder #(.NUM_REGS(16), .RESP_DELAY(3)) u1 (
    .clock(clk), .reset(rst),
    .auto_in_a_valid(a_valid[1]), .auto_in_a_ready(a_ready[1]),
    .auto_in_a_bits_opcode(a_op[1]), .auto_in_a_bits_address(a_addr[1]),
    .auto_in_a_bits_source(a_src[1]), .auto_in_a_bits_data(a_data[1]),
    .auto_in_d_valid(d_valid[1]), .auto_in_d_ready(d_ready[1]),
    .auto_in_d_bits_opcode(d_op[1]), .auto_in_d_bits_param(d_param[1]),
    .auto_in_d_bits_size(d_size[1]), .auto_in_d_bits_source(d_src[1]),
    .auto_in_d_bits_sink(d_sink[1]), .auto_in_d_bits_denied(d_den[1]),
    .auto_in_d_bits_data(d_data[1]), .auto_in_d_bits_corrupt(d_cor[1])
  );

  function automatic int dly(input int u);
    return (u == 0) ? 0 : 3;
  endfunction

  task automatic clear_model();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 16; i++) mem[u][i] = 32'd0;
  endtask

  // Reference: expected D fields for one request, updating the model array.
  task automatic model(input int u, input logic [2:0] op, input logic [8:0] addr,
                       input logic [31:0] wd, output logic [2:0] eop,
                       output logic eden, output logic [31:0] edat, output logic ecor);
    int idx;
    bit bad_addr;
    idx = int'(addr) / 4;
    bad_addr = (int'(addr) % 4 != 0) || (idx >= 16);
    eop = 3'd0; eden = 1'b1; edat = 32'd0; ecor = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        eden = bad_addr;
        if (!bad_addr) mem[u][idx] = wd;
      end
      3'd4: begin
        eop = 3'd1; eden = bad_addr; ecor = bad_addr;
        if (!bad_addr) edat = mem[u][idx];
      end
      3'd2, 3'd3: begin
        eop = 3'd1; ecor = 1'b1;
      end
      default: ;
    endcase
  endtask

  // Drives one request, measures latency (negedges after acceptance edge) and
  // captures the response; stable=0 if D moves under backpressure or a_ready
  // rises while busy.
  task automatic send_req(input int u, input logic [2:0] op, input logic [8:0] addr,
                          input logic src, input logic [31:0] wd, input int hold,
                          output int lat, output logic [2:0] rop, output logic rden,
                          output logic [31:0] rdat, output logic rcor, output logic rsrc,
                          output logic [1:0] rsize, output bit stable);
    logic [39:0] snap;
    lat = -1; stable = 1; rop = 3'd0; rden = 1'b0; rdat = 32'd0;
    rcor = 1'b0; rsrc = 1'b0; rsize = 2'd0;
    @(negedge clk);
    a_valid[u] = 1'b1; a_op[u] = op; a_addr[u] = addr; a_src[u] = src; a_data[u] = wd;
    d_ready[u] = 1'b0;
    for (int n = 0; n < 20 && !a_ready[u]; n++) @(negedge clk);
    @(posedge clk);
    #1 a_valid[u] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (d_valid[u]) begin
        lat = k;
        break;
      end
      if (a_ready[u]) stable = 0;
    end
    if (lat < 0) return;
    rop = d_op[u]; rden = d_den[u]; rdat = d_data[u]; rcor = d_cor[u];
    rsrc = d_src[u]; rsize = d_size[u];
    snap = {d_valid[u], d_op[u], d_den[u], d_data[u], d_cor[u], d_src[u], a_ready[u]};
    repeat (hold) begin
      @(negedge clk);
      if (snap !== {d_valid[u], d_op[u], d_den[u], d_data[u], d_cor[u], d_src[u], a_ready[u]})
        stable = 0;
    end
    d_ready[u] = 1'b1;
    @(posedge clk);
    #1 d_ready[u] = 1'b0;
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      total++;
      if ({a_ready[u], d_valid[u], d_op[u], d_param[u], d_src[u], d_sink[u], d_den[u],
           d_data[u], d_cor[u]} !== {1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0}) begin
        bad++;
        $display("FAIL reset_state u%0d: a_ready=%0b d_valid=%0b op=%0d den=%0b data=%h cor=%0b, want 1 0 0 0 0 0",
                 u, a_ready[u], d_valid[u], d_op[u], d_den[u], d_data[u], d_cor[u]);
      end
    end
  endtask

  task automatic test_put_get();
    int lat; logic [2:0] op; logic den, cor, src; logic [31:0] dat; logic [1:0] sz; bit st;
    logic [2:0] eop; logic eden, ecor; logic [31:0] edat;
    model(0, 3'd0, 9'h008, 32'hDEADBEEF, eop, eden, edat, ecor);
    send_req(0, 3'd0, 9'h008, 1'b0, 32'hDEADBEEF, 0, lat, op, den, dat, cor, src, sz, st);
    total++;
    if ({lat, op, den} !== {32'd1, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL put_ack: lat=%0d op=%0d den=%0b, want lat=1 op=0 den=0", lat, op, den);
    end
    model(0, 3'd4, 9'h008, 32'd0, eop, eden, edat, ecor);
    send_req(0, 3'd4, 9'h008, 1'b0, 32'd0, 0, lat, op, den, dat, cor, src, sz, st);
    total++;
    if ({lat, op, den, dat, cor, sz} !== {32'd1, 3'd1, 1'b0, 32'hDEADBEEF, 1'b0, 2'd2}) begin
      bad++;
      $display("FAIL get_data: lat=%0d op=%0d den=%0b data=%h cor=%0b size=%0d, want 1 1 0 deadbeef 0 2",
               lat, op, den, dat, cor, sz);
    end
  endtask

  task automatic test_decode();
    int lat; logic [2:0] op; logic den, cor, src; logic [31:0] dat; logic [1:0] sz; bit st;
    logic [2:0] eop; logic eden, ecor; logic [31:0] edat;
    model(0, 3'd4, 9'h00C, 32'd0, eop, eden, edat, ecor);
    send_req(0, 3'd4, 9'h00C, 1'b0, 32'd0, 0, lat, op, den, dat, cor, src, sz, st);
    total++;
    if ({op, den, dat, cor} !== {3'd1, 1'b0, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL get_zero: op=%0d den=%0b data=%h cor=%0b, want 1 0 00000000 0", op, den, dat, cor);
    end
    model(0, 3'd4, 9'h040, 32'd0, eop, eden, edat, ecor);
    send_req(0, 3'd4, 9'h040, 1'b0, 32'd0, 0, lat, op, den, dat, cor, src, sz, st);
    total++;
    if ({op, den, dat, cor} !== {3'd1, 1'b1, 32'd0, 1'b1}) begin
      bad++;
      $display("FAIL get_oor: op=%0d den=%0b data=%h cor=%0b, want 1 1 00000000 1", op, den, dat, cor);
    end
    model(0, 3'd0, 9'h004, 32'h0BADF00D, eop, eden, edat, ecor);
    send_req(0, 3'd0, 9'h004, 1'b0, 32'h0BADF00D, 0, lat, op, den, dat, cor, src, sz, st);
    model(0, 3'd0, 9'h005, 32'h11111111, eop, eden, edat, ecor);
    send_req(0, 3'd0, 9'h005, 1'b0, 32'h11111111, 0, lat, op, den, dat, cor, src, sz, st);
    total++;
    if ({op, den, cor} !== {3'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL put_misaligned: op=%0d den=%0b cor=%0b, want 0 1 0", op, den, cor);
    end
    model(0, 3'd4, 9'h004, 32'd0, eop, eden, edat, ecor);
    send_req(0, 3'd4, 9'h004, 1'b0, 32'd0, 0, lat, op, den, dat, cor, src, sz, st);
    total++;
    if ({den, dat} !== {1'b0, edat}) begin
      bad++;
      $display("FAIL get_after_denied: den=%0b data=%h, want 0 %h", den, dat, edat);
    end
  endtask

  // Put then Get with the Get already waiting on A; measures acceptance gap.
  task automatic run_b2b(input int u, input int hold, input string tag);
    logic [2:0] eop; logic eden, ecor; logic [31:0] edat;
    logic [31:0] wv; logic [8:0] addr;
    int acc_cyc [2]; int nacc = 0; int nresp = 0; int dv_cycles = 0;
    logic [2:0] rop [2]; logic [31:0] rdat [2]; logic [35:0] held;
    bit stable = 1; bit will_acc; bit will_hs;
    wv = $urandom;
    addr = 9'(4 * $urandom_range(0, 15));
    acc_cyc[0] = 0; acc_cyc[1] = 0; rop[0] = 0; rop[1] = 0; rdat[0] = 0; rdat[1] = 0;
    held = 36'd0;
    model(u, 3'd0, addr, wv, eop, eden, edat, ecor);
    model(u, 3'd4, addr, 32'd0, eop, eden, edat, ecor);
    @(negedge clk);
    a_valid[u] = 1'b1; a_op[u] = 3'd0; a_addr[u] = addr; a_src[u] = 1'b0; a_data[u] = wv;
    d_ready[u] = 1'b0;
    for (int cyc = 0; cyc < 80 && nresp < 2; cyc++) begin
      if (d_valid[u]) begin
        if (dv_cycles == 0) held = {d_op[u], d_den[u], d_data[u]};
        else if (held !== {d_op[u], d_den[u], d_data[u]}) stable = 0;
        dv_cycles++;
        d_ready[u] = (nresp > 0) || (dv_cycles > hold);
      end
      will_acc = a_valid[u] && a_ready[u];
      will_hs = d_valid[u] && d_ready[u];
      if (will_hs) begin
        rop[nresp] = d_op[u];
        rdat[nresp] = d_data[u];
      end
      @(posedge clk);
      #1;
      if (will_acc && nacc < 2) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        if (nacc == 1) begin
          a_op[u] = 3'd4; a_data[u] = 32'd0;
        end else begin
          a_valid[u] = 1'b0;
        end
      end
      if (will_hs) begin
        nresp++;
        dv_cycles = 0;
        d_ready[u] = 1'b0;
      end
      @(negedge clk);
    end
    a_valid[u] = 1'b0; d_ready[u] = 1'b0;
    total++;
    if (nresp != 2 || nacc != 2) begin
      bad++;
      $display("FAIL %s_timeout u%0d: accepted=%0d responses=%0d, want 2 2", tag, u, nacc, nresp);
    end
    total++;
    if (acc_cyc[1] - acc_cyc[0] != dly(u) + 2 + hold) begin
      bad++;
      $display("FAIL %s_gap u%0d: gap=%0d, want %0d", tag, u, acc_cyc[1] - acc_cyc[0], dly(u) + 2 + hold);
    end
    total++;
    if ({rop[0], rop[1], rdat[1], stable} !== {3'd0, 3'd1, edat, 1'b1}) begin
      bad++;
      $display("FAIL %s_resp u%0d: ops=%0d/%0d data=%h stable=%0b, want 0/1 %h 1",
               tag, u, rop[0], rop[1], rdat[1], stable, edat);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [2:0] op; logic den, cor, src; logic [31:0] dat; logic [1:0] sz; bit st;
    logic [2:0] eop; logic eden, ecor; logic [31:0] edat;
    model(0, 3'd4, 9'h008, 32'd0, eop, eden, edat, ecor);
    send_req(0, 3'd4, 9'h008, 1'b1, 32'd0, 5, lat, op, den, dat, cor, src, sz, st);
    total++;
    if ({st, op, dat, src} !== {1'b1, 3'd1, edat, 1'b1}) begin
      bad++;
      $display("FAIL hold_stable: stable=%0b op=%0d data=%h src=%0b, want 1 1 %h 1", st, op, dat, src, edat);
    end
    run_b2b(0, 5, "backpressure");
  endtask

  task automatic test_back_to_back();
    run_b2b(0, 0, "b2b");
    run_b2b(1, 0, "b2b");
  endtask

  task automatic test_delay();
    int lat; logic [2:0] op; logic den, cor, src; logic [31:0] dat; logic [1:0] sz; bit st;
    logic [2:0] eop; logic eden, ecor; logic [31:0] edat;
    model(1, 3'd1, 9'h014, 32'hA5A50001, eop, eden, edat, ecor);
    send_req(1, 3'd1, 9'h014, 1'b1, 32'hA5A50001, 0, lat, op, den, dat, cor, src, sz, st);
    model(1, 3'd4, 9'h014, 32'd0, eop, eden, edat, ecor);
    send_req(1, 3'd4, 9'h014, 1'b1, 32'd0, 0, lat, op, den, dat, cor, src, sz, st);
    total++;
    if ({lat, src, dat, st} !== {32'd4, 1'b1, edat, 1'b1}) begin
      bad++;
      $display("FAIL delay_get: lat=%0d src=%0b data=%h quiet=%0b, want 4 1 %h 1", lat, src, dat, st, edat);
    end
    model(1, 3'd2, 9'h014, 32'h5, eop, eden, edat, ecor);
    send_req(1, 3'd2, 9'h014, 1'b0, 32'h5, 0, lat, op, den, dat, cor, src, sz, st);
    total++;
    if ({op, den, cor, dat} !== {3'd1, 1'b1, 1'b1, 32'd0}) begin
      bad++;
      $display("FAIL arith_denied: op=%0d den=%0b cor=%0b data=%h, want 1 1 1 00000000", op, den, cor, dat);
    end
  endtask

  task automatic test_random();
    int lat; logic [2:0] op; logic den, cor, src; logic [31:0] dat; logic [1:0] sz; bit st;
    logic [2:0] eop; logic eden, ecor; logic [31:0] edat;
    logic [2:0] rop; logic [8:0] raddr; logic rsrc; logic [31:0] rwd; int hold;
    for (int u = 0; u < 2; u++) begin
      for (int t = 0; t < 25; t++) begin
        if ($urandom_range(0, 3) == 0) rop = 3'($urandom_range(0, 7));
        else rop = ($urandom_range(0, 1) == 1) ? 3'd4 : 3'($urandom_range(0, 1));
        raddr = ($urandom_range(0, 4) == 0) ? 9'($urandom_range(0, 511))
                                            : 9'(4 * $urandom_range(0, 18));
        rsrc = 1'($urandom_range(0, 1));
        rwd = $urandom;
        hold = $urandom_range(0, 3);
        model(u, rop, raddr, rwd, eop, eden, edat, ecor);
        send_req(u, rop, raddr, rsrc, rwd, hold, lat, op, den, dat, cor, src, sz, st);
        total++;
        if ({lat, op, den, dat, cor, src, sz, st} !==
            {dly(u) + 1, eop, eden, edat, ecor, rsrc, 2'd2, 1'b1}) begin
          bad++;
          $display("FAIL random u%0d #%0d op=%0d addr=%h: lat=%0d op=%0d den=%0b data=%h cor=%0b src=%0b size=%0d stable=%0b, want lat=%0d op=%0d den=%0b data=%h cor=%0b src=%0b",
                   u, t, rop, raddr, lat, op, den, dat, cor, src, sz, st,
                   dly(u) + 1, eop, eden, edat, ecor, rsrc);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [2:0] op; logic den, cor, src; logic [31:0] dat; logic [1:0] sz; bit st;
    logic [2:0] eop; logic eden, ecor; logic [31:0] edat;
    bit seen = 0;
    model(0, 3'd0, 9'h010, 32'h12345678, eop, eden, edat, ecor);
    send_req(0, 3'd0, 9'h010, 1'b0, 32'h12345678, 0, lat, op, den, dat, cor, src, sz, st);
    @(negedge clk);
    a_valid[0] = 1'b1; a_op[0] = 3'd4; a_addr[0] = 9'h010; d_ready[0] = 1'b0;
    @(posedge clk);
    #1 a_valid[0] = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = d_valid[0];
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL reset_mid_setup: d_valid=0 within 10 cycles, want 1");
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({d_valid[0], a_ready[0], a_ready[1]} !== 3'b011) begin
      bad++;
      $display("FAIL reset_mid_async: d_valid=%0b a_ready=%0b/%0b, want 0 1/1", d_valid[0], a_ready[0], a_ready[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    model(0, 3'd4, 9'h010, 32'd0, eop, eden, edat, ecor);
    send_req(0, 3'd4, 9'h010, 1'b0, 32'd0, 0, lat, op, den, dat, cor, src, sz, st);
    total++;
    if ({lat, den, dat} !== {32'd1, 1'b0, edat}) begin
      bad++;
      $display("FAIL reset_clears_regs: lat=%0d den=%0b data=%h, want 1 0 %h", lat, den, dat, edat);
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      a_valid[u] = 1'b0; a_op[u] = 3'd0; a_addr[u] = 9'd0; a_src[u] = 1'b0;
      a_data[u] = 32'd0; d_ready[u] = 1'b0;
    end
    clear_model();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_put_get();
    test_decode();
    test_backpressure();
    test_back_to_back();
    test_delay();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
